// File: rtl/dma_copy_engine_pkg.sv
// Shared types and constants for the word-by-word DMA copy engine.
// Holds the FSM state encoding, bus widths and the word-address helper.
package dma_copy_engine_pkg;

    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Byte address of word idx from base; wraps modulo 2^ADDR_W with no alignment check.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + (ADDR_W'(idx) * ADDR_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// Single-channel memory-to-memory copy engine: alternates one READ and one WRITE
// cycle per 32-bit word against a combinational-read, edge-write memory.
module dma_copy_engine
    import dma_copy_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       WriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       MemoryOut
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_busy;
    logic              r_done;

    logic              w_more_words;
    logic [LEN_W-1:0]  w_idx_next;

    assign w_idx_next   = r_idx + LEN_W'(1);
    // Widened by one bit so the last index of a 65535-word copy cannot wrap the compare.
    assign w_more_words = ({1'b0, r_idx} + (LEN_W+1)'(1)) < {1'b0, r_len};

    // NOTE: every memory-side output is a register computed for the *next* state, so
    //       the async reset clears them immediately and no write can commit after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_buf       <= '0;
            r_addr      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; these defaults hold unless a state below overrides.
            r_addr      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_buf <= '0;
                    if (start) begin
                        r_src  <= src_addr;
                        r_dst  <= dst_addr;
                        r_len  <= len_words;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (len_words != '0) begin
                            r_state    <= ST_READ;
                            r_mem_read <= 1'b1;
                            r_addr     <= src_addr;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_buf       <= MemoryOut;
                    r_mem_write <= 1'b1;
                    r_addr      <= word_addr(r_dst, r_idx);
                    r_state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_idx <= w_idx_next;
                    r_buf <= '0;
                    if (w_more_words) begin
                        r_state    <= ST_READ;
                        r_mem_read <= 1'b1;
                        r_addr     <= word_addr(r_src, w_idx_next);
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign Address   = r_addr;
    assign WriteData = r_buf;
    assign MemRead   = r_mem_read;
    assign MemWrite  = r_mem_write;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: byte-addressed memory model plus a
// scoreboard of expected read/write bus operations.
module tb_dma_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemoryOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_op_t;

    bus_op_t     sb[$];
    logic [7:0]  mem[logic [31:0]];

    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;

    dma_copy_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemoryOut (MemoryOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] ba;
            ba = a + 32'(b);
            w[8*b +: 8] = mem.exists(ba) ? mem[ba] : 8'h00;
        end
        return w;
    endfunction

    // Sole writer of the memory model: DUT writes and bench preloads both land here.
    always @(posedge clk) begin
        if (MemWrite) begin
            for (int b = 0; b < 4; b++) mem[Address + 32'(b)] = WriteData[8*b +: 8];
        end
        if (pl_en) begin
            for (int b = 0; b < 4; b++) mem[pl_addr + 32'(b)] = pl_data[8*b +: 8];
        end
        #1 MemoryOut = rd_word(Address);
    end

    // Bus monitor: strobe exclusivity, quiet bus when idle/done, scoreboard compare.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rw_exclusive", {63'd0, MemRead & MemWrite}, 64'd0);
            if (!busy || done) begin
                check("quiet_addr",   {32'd0, Address},   64'd0);
                check("quiet_wdata",  {32'd0, WriteData}, 64'd0);
                check("quiet_strobe", {62'd0, MemRead, MemWrite}, 64'd0);
            end
            if (MemRead || MemWrite) begin
                if (sb.size() == 0) begin
                    check("unexpected_op", {32'd0, Address}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    bus_op_t e;
                    e = sb.pop_front();
                    check("op_kind", {63'd0, MemWrite}, {63'd0, e.wr});
                    check("op_addr", {32'd0, Address}, {32'd0, e.addr});
                    if (e.wr) check("op_wdata", {32'd0, WriteData}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // mode 0: plain copy; 1: re-pulse start with new params mid-copy; 2: start in DONE cycle.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n, input int mode);
        logic [31:0] exp_data[$];
        int          cyc;
        int          done_cnt;
        int          done_cyc;
        exp_data.delete();
        for (int k = 0; k < n; k++) begin
            logic [31:0] sa, da;
            sa = s + 32'(4*k);
            da = d + 32'(4*k);
            exp_data.push_back(rd_word(sa));
            sb.push_back('{wr: 1'b0, addr: sa, data: 32'd0});
            sb.push_back('{wr: 1'b1, addr: da, data: rd_word(sa)});
        end
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len_words = 16'(n);
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        done_cyc = 0;
        for (cyc = 1; cyc <= 2*n + 5; cyc++) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            check("busy", {63'd0, busy}, {63'd0, cyc <= 2*n + 1});
            if (mode == 1 && cyc == 2) begin
                start = 1'b1; src_addr = 32'h500; dst_addr = 32'h900; len_words = 16'd1;
            end
            if (mode == 2 && cyc == 2*n + 1) start = 1'b1;
            if (cyc == 2*n + 2 || (mode == 1 && cyc == 3)) start = 1'b0;
            @(negedge clk);
        end
        check("done_cycle", 64'(done_cyc), 64'(2*n + 1));
        check("done_count", 64'(done_cnt), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        for (int k = 0; k < n; k++) begin
            check("dst_mem", {32'd0, rd_word(d + 32'(4*k))}, {32'd0, exp_data[k]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0; MemoryOut = '0;
        #1;
        check("rst_busy",   {63'd0, busy},     64'd0);
        check("rst_done",   {63'd0, done},     64'd0);
        check("rst_addr",   {32'd0, Address},  64'd0);
        check("rst_wdata",  {32'd0, WriteData}, 64'd0);
        check("rst_strobe", {62'd0, MemRead, MemWrite}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic three-word copy.
        preload(32'h100, 32'h1111_1111);
        preload(32'h104, 32'h2222_2222);
        preload(32'h108, 32'h3333_3333);
        run_copy(32'h100, 32'h200, 3, 0);
        check("copy_w0", {32'd0, rd_word(32'h200)}, 64'h1111_1111);
        check("copy_w1", {32'd0, rd_word(32'h204)}, 64'h2222_2222);
        check("copy_w2", {32'd0, rd_word(32'h208)}, 64'h3333_3333);

        // Zero-length copy: done in cycle 1, no bus traffic.
        run_copy(32'h100, 32'h300, 0, 0);

        // Source address wraps past 2^32.
        preload(32'hFFFF_FFFC, 32'hA5A5_A5A5);
        preload(32'h0000_0000, 32'h5A5A_5A5A);
        run_copy(32'hFFFF_FFFC, 32'h600, 2, 0);

        // Second start with new parameters mid-copy is ignored.
        preload(32'h500, 32'hBAD0_BAD0);
        run_copy(32'h100, 32'h700, 3, 1);
        check("no_stray_write", {32'd0, rd_word(32'h900)}, 64'd0);

        // Start in the DONE cycle is ignored.
        run_copy(32'h104, 32'h800, 1, 2);

        // Reset during the second word's WRITE aborts the copy.
        for (int k = 0; k < 4; k++) begin
            preload(32'h300 + 32'(4*k), 32'hC000_0000 + 32'(k));
            preload(32'h400 + 32'(4*k), 32'hDEAD_BEEF);
        end
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{wr: 1'b0, addr: 32'h300 + 32'(4*k), data: 32'd0});
            sb.push_back('{wr: 1'b1, addr: 32'h400 + 32'(4*k), data: 32'hC000_0000 + 32'(k)});
        end
        @(negedge clk);
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h400; len_words = 16'd4;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (cyc = 1; cyc < 4; cyc++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_in_write", {62'd0, MemWrite, MemRead}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   {63'd0, busy},     64'd0);
        check("abort_done",   {63'd0, done},     64'd0);
        check("abort_addr",   {32'd0, Address},  64'd0);
        check("abort_wdata",  {32'd0, WriteData}, 64'd0);
        check("abort_strobe", {62'd0, MemRead, MemWrite}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
            check("abort_idle", {63'd0, busy}, 64'd0);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_w0", {32'd0, rd_word(32'h400)}, 64'hC000_0000);
        check("abort_w1", {32'd0, rd_word(32'h404)}, 64'hDEAD_BEEF);
        check("abort_w2", {32'd0, rd_word(32'h408)}, 64'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
